instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_enc_pkg.sv | 30 +++
 rtl/instr_enc_pack.sv | 56 +++++
 rtl/instr_encoder.sv | 99 +++++++++
 tb/tb_instr_encoder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_enc_pkg.sv
// Shared types and RV32I encoding constants for the instruction encoder.
// Build option: ENC_IMM_CHECK_EN enables immediate range checking in instr_enc_pack.
package instr_enc_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_AND  = 3'd1,
    OP_ADDI = 3'd2,
    OP_LW   = 3'd3,
    OP_SW   = 3'd4,
    OP_BEQ  = 3'd5
  } op_kind_e;

  localparam logic [6:0] R_TYPE  = 7'b0110011;
  localparam logic [6:0] RI_TYPE = 7'b0010011;
  localparam logic [6:0] LW      = 7'b0000011;
  localparam logic [6:0] SW      = 7'b0100011;
  localparam logic [6:0] BR      = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  localparam int          PROG_DEPTH = 64;
  localparam logic [31:0] NOP_WORD   = 32'h0000_0013;

endpackage

// File: rtl/instr_enc_pack.sv
// Combinational RV32I field packing plus illegal-op and immediate-range flags.
// Build option: ENC_IMM_CHECK_EN turns on the immediate range check (o_imm_bad).
module instr_enc_pack
  import instr_enc_pkg::*;
(
  input  logic [2:0]  i_op_kind,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_illegal,
  output logic        o_imm_bad
);

  always_comb begin
    o_word    = NOP_WORD;
    o_illegal = 1'b0;
    case (i_op_kind)
      OP_ADD:  o_word = {F7_BASE, i_rs2, i_rs1, F3_ADD, i_rd, R_TYPE};
      OP_AND:  o_word = {F7_BASE, i_rs2, i_rs1, F3_AND, i_rd, R_TYPE};
      OP_ADDI: o_word = {i_imm[11:0], i_rs1, F3_ADD, i_rd, RI_TYPE};
      OP_LW:   o_word = {i_imm[11:0], i_rs1, F3_LW, i_rd, LW};
      OP_SW:   o_word = {i_imm[11:5], i_rs2, i_rs1, F3_SW, i_imm[4:0], SW};
      OP_BEQ:  o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, F3_BEQ,
                         i_imm[4:1], i_imm[11], BR};
      default: o_illegal = 1'b1;
    endcase
  end

`ifdef ENC_IMM_CHECK_EN
  logic signed [31:0] w_imm_s;
  logic               w_i_ok;
  logic               w_b_ok;

  assign w_imm_s = i_imm;
  assign w_i_ok  = (w_imm_s >= -32'sd2048) && (w_imm_s <= 32'sd2047);
  // Branch targets are halfword aligned, so bit 0 must be clear.
  assign w_b_ok  = (w_imm_s >= -32'sd4096) && (w_imm_s <= 32'sd4094) && !i_imm[0];

  always_comb begin
    o_imm_bad = 1'b0;
    case (i_op_kind)
      OP_ADDI, OP_LW, OP_SW: o_imm_bad = !w_i_ok;
      OP_BEQ:                o_imm_bad = !w_b_ok;
      default:               o_imm_bad = 1'b0;
    endcase
  end
`else
  logic w_unused_imm;

  assign w_unused_imm = ^i_imm[31:13];
  assign o_imm_bad    = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Encodes one instruction request into an RV32I word and writes it to a 64-word program memory.
// Build option: ENC_IMM_CHECK_EN rejects out-of-range immediates (no write, err set).
module instr_encoder
  import instr_enc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op_kind,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic        imem_we,
  output logic [7:0]  imem_addr,
  output logic [31:0] imem_wdata,
  output logic [6:0]  count,
  output logic        full,
  output logic        err,
  output logic        busy
);

  typedef enum logic {S_IDLE, S_WRITE} state_e;

  state_e      r_state;
  logic [6:0]  r_count;
  logic        r_err;
  logic        r_we;
  logic [7:0]  r_addr;
  logic [31:0] r_wdata;

  logic [31:0] w_word;
  logic        w_illegal;
  logic        w_imm_bad;
  logic        w_full;
  logic        w_accept;

  instr_enc_pack u_pack (
    .i_op_kind (op_kind),
    .i_rd      (rd),
    .i_rs1     (rs1),
    .i_rs2     (rs2),
    .i_imm     (imm),
    .o_word    (w_word),
    .o_illegal (w_illegal),
    .o_imm_bad (w_imm_bad)
  );

  assign w_full   = (r_count == 7'(PROG_DEPTH));
  assign in_ready = (r_state == S_IDLE) && !w_full && !clear;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_count <= 7'd0;
      r_err   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 8'd0;
      r_wdata <= 32'd0;
    end else if (clear) begin
      r_state <= S_IDLE;
      r_count <= 7'd0;
      r_err   <= 1'b0;
      r_we    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_WRITE;
            r_we    <= !w_imm_bad;
            r_addr  <= {r_count[5:0], 2'b00};
            r_wdata <= w_word;
            r_err   <= r_err | w_illegal | w_imm_bad;
          end
        end
        S_WRITE: begin
          // A rejected immediate still spends this cycle here but leaves count alone.
          r_state <= S_IDLE;
          r_we    <= 1'b0;
          if (r_we) r_count <= r_count + 7'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Reset or clear arriving during WRITE must kill the strobe in that same cycle.
  assign imem_we    = r_we && reset && !clear;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign count      = r_count;
  assign full       = w_full;
  assign err        = r_err;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vector table, fill/clear/reset sequences,
// and randomized requests against a behavioural model (honours ENC_IMM_CHECK_EN).
module tb_instr_encoder;

  logic        clk;
  logic        reset;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op_kind;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [6:0]  count;
  logic        full;
  logic        err;
  logic        busy;

  int tests;
  int fails;
  int m_count;
  bit m_err;

  instr_encoder dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_kind    (op_kind),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .imm        (imm),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .count      (count),
    .full       (full),
    .err        (err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: run did not finish, got running required finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference encoding built from the RV32I field positions with plain integer arithmetic.
  function automatic logic [31:0] ref_enc(input int op, input int f_rd, input int f_rs1,
                                          input int f_rs2, input int f_imm,
                                          output bit ill, output bit bad);
    int w;
    ill = 1'b0;
    bad = 1'b0;
    case (op)
      0: w = (f_rs2 << 20) + (f_rs1 << 15) + (f_rd << 7) + 51;
      1: w = (f_rs2 << 20) + (f_rs1 << 15) + (7 << 12) + (f_rd << 7) + 51;
      2: w = ((f_imm & 4095) << 20) + (f_rs1 << 15) + (f_rd << 7) + 19;
      3: w = ((f_imm & 4095) << 20) + (f_rs1 << 15) + (2 << 12) + (f_rd << 7) + 3;
      4: w = (((f_imm >> 5) & 127) << 25) + (f_rs2 << 20) + (f_rs1 << 15) + (2 << 12)
             + ((f_imm & 31) << 7) + 35;
      5: w = (((f_imm >> 12) & 1) << 31) + (((f_imm >> 5) & 63) << 25) + (f_rs2 << 20)
             + (f_rs1 << 15) + (((f_imm >> 1) & 15) << 8) + (((f_imm >> 11) & 1) << 7) + 99;
      default: begin
        w   = 19;
        ill = 1'b1;
      end
    endcase
`ifdef ENC_IMM_CHECK_EN
    if (op >= 2 && op <= 4) bad = (f_imm < -2048) || (f_imm > 2047);
    else if (op == 5)       bad = (f_imm < -4096) || (f_imm > 4094) || ((f_imm & 1) != 0);
`endif
    return w;
  endfunction

  // Starts and ends 1 time unit after a rising edge with the DUT in IDLE.
  task automatic do_req(input int op, input int f_rd, input int f_rs1, input int f_rs2,
                        input int f_imm, input logic [31:0] tbl_word, input bit from_tbl);
    bit          ill;
    bit          bad;
    logic [31:0] mw;
    logic [31:0] exp_w;
    int          n;
    mw       = ref_enc(op, f_rd, f_rs1, f_rs2, f_imm, ill, bad);
    exp_w    = from_tbl ? tbl_word : mw;
    op_kind  = 3'(op);
    rd       = 5'(f_rd);
    rs1      = 5'(f_rs1);
    rs2      = 5'(f_rs2);
    imm      = f_imm;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("busy_write", 32'(busy), 32'd1);
    chk("imem_we", 32'(imem_we), bad ? 32'd0 : 32'd1);
    if (!bad) begin
      chk("imem_addr", 32'(imem_addr), 32'(m_count * 4));
      chk("imem_wdata", imem_wdata, exp_w);
    end
    @(posedge clk); #1;
    if (!bad) m_count++;
    m_err = m_err | ill | bad;
    chk("count", 32'(count), 32'(m_count));
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    @(negedge clk);
    chk("ready_in_clear", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    clear   = 1'b0;
    m_count = 0;
    m_err   = 1'b0;
    chk("count_after_clear", 32'(count), 32'd0);
    chk("err_after_clear", 32'(err), 32'd0);
  endtask

  typedef struct {
    int          op;
    int          rd;
    int          rs1;
    int          rs2;
    int          imm;
    logic [31:0] word;
    bit          clr_before;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tests = 0; fails = 0; m_count = 0; m_err = 1'b0;
    tbl[0] = '{0, 3, 1, 2, 0,   32'h002081B3, 1'b0};
    tbl[1] = '{2, 5, 0, 31, 10, 32'h00A00293, 1'b1};
    tbl[2] = '{3, 6, 2, 7, 8,   32'h00812303, 1'b0};
    tbl[3] = '{4, 9, 2, 6, 12,  32'h00612623, 1'b0};
    tbl[4] = '{5, 4, 1, 2, -8,  32'hFE208CE3, 1'b0};
    tbl[5] = '{1, 7, 8, 9, 0,   32'h009473B3, 1'b0};
    tbl[6] = '{7, 1, 1, 1, 0,   32'h00000013, 1'b0};

    reset = 1'b0; clear = 1'b0; in_valid = 1'b0;
    op_kind = 3'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; imm = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].clr_before) clear_pulse();
      do_req(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, tbl[i].word, 1'b1);
    end
    chk("illegal_err", 32'(err), 32'd1);
    clear_pulse();

    // Fill to 64 words, then hold a request against a full memory.
    for (int i = 0; i < 64; i++) do_req(0, i % 32, 1, 2, 0, 32'd0, 1'b0);
    chk("full_set", 32'(full), 32'd1);
    chk("full_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("full_no_we", 32'(imem_we), 32'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("full_count_hold", 32'(count), 32'd64);
    clear_pulse();
    chk("full_cleared", 32'(full), 32'd0);
    do_req(0, 3, 1, 2, 0, 32'h002081B3, 1'b1);

    // Clear arriving in the WRITE cycle.
    op_kind = 3'd1; rd = 5'd4; rs1 = 5'd5; rs2 = 5'd6; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; clear = 1'b1;
    @(negedge clk);
    chk("clr_write_busy", 32'(busy), 32'd1);
    chk("clr_write_we", 32'(imem_we), 32'd0);
    @(posedge clk); #1;
    clear = 1'b0; m_count = 0; m_err = 1'b0;
    chk("clr_write_count", 32'(count), 32'd0);
    chk("clr_write_idle", 32'(busy), 32'd0);
    do_req(2, 1, 2, 0, -1, 32'd0, 1'b0);

    // Reset arriving in the WRITE cycle.
    op_kind = 3'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; reset = 1'b0;
    @(negedge clk);
    chk("rst_write_we", 32'(imem_we), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1; m_count = 0; m_err = 1'b0;
    chk("rst_write_count", 32'(count), 32'd0);
    chk("rst_write_err", 32'(err), 32'd0);
    chk("rst_write_wdata", imem_wdata, 32'd0);

    // Out-of-range immediates: rejected with the check, truncated without it.
    do_req(2, 5, 1, 0, 4096, 32'd0, 1'b0);
    do_req(5, 0, 3, 4, 4095, 32'd0, 1'b0);
    do_req(4, 0, 3, 4, -2049, 32'd0, 1'b0);
`ifdef ENC_IMM_CHECK_EN
    chk("immchk_err", 32'(err), 32'd1);
`else
    chk("notrunc_err", 32'(err), 32'd0);
`endif
    clear_pulse();

    for (int i = 0; i < 300; i++) begin
      int r;
      int op;
      int f_imm;
      if (m_count == 64 || ($urandom % 32) == 0) clear_pulse();
      r  = int'($urandom % 10);
      op = (r < 8) ? (r % 6) : (r - 2);
      case ($urandom % 4)
        0:       f_imm = int'($urandom);
        1:       f_imm = int'($urandom_range(0, 8191)) - 4096;
        default: f_imm = int'($urandom_range(0, 4095)) - 2048;
      endcase
      if (op == 5 && ($urandom % 2) == 0) f_imm = f_imm & ~1;
      if (($urandom % 4) == 0) begin
        @(posedge clk); #1;
      end
      do_req(op, int'($urandom % 32), int'($urandom % 32), int'($urandom % 32), f_imm,
             32'd0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
